// File: rtl/piso_sequencer_pkg.sv
// rtl/piso_sequencer_pkg.sv - shared state encoding and sizing helper for the PISO sequencer
package piso_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOADING  = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// rtl/piso_bit_timer.sv - bit-period divider producing one tick every DIV enabled cycles
module piso_bit_timer
  import piso_sequencer_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] divcnt;

  assign tick = en && (divcnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      divcnt <= '0;
    end else if (en) begin
      divcnt <= tick ? '0 : divcnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_sequencer.sv
// rtl/piso_sequencer.sv - accepts words over VALID/READY and drives PISO LOAD/CE, MSB first
module piso_sequencer
  import piso_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             VALID,
  output logic             READY,
  output logic [WIDTH-1:0] PI,
  output logic             LOAD,
  output logic             CE,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = clog2_min1(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [BW-1:0]    bitcnt, bitcnt_nx;
  logic [WIDTH-1:0] pi_nx;
  logic             done_nx;
  logic             tick;

  piso_bit_timer #(.DIV(DIV)) u_timer (
    .clk   (CLK),
    .reset (RESET),
    .clear (state == IDLE),
    .en    (state != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      bitcnt <= '0;
      PI     <= '0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nx;
      bitcnt <= bitcnt_nx;
      PI     <= pi_nx;
      DONE   <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    pi_nx     = PI;
    done_nx   = 1'b0;
    READY     = 1'b0;
    LOAD      = 1'b0;
    CE        = 1'b0;
    BUSY      = 1'b0;
    case (state)
      IDLE: begin
        READY = 1'b1;
        if (VALID) begin
          pi_nx    = I;
          state_nx = LOADING;
        end
      end
      LOADING: begin
        LOAD = 1'b1;
        CE   = tick;
        BUSY = 1'b1;
        if (tick) begin
          bitcnt_nx = '0;
          state_nx  = SHIFTING;
        end
      end
      SHIFTING: begin
        BUSY = 1'b1;
        // The final bit keeps its whole period; no shift is issued after it.
        CE   = tick && (bitcnt < LAST_BIT);
        if (tick) begin
          bitcnt_nx = bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_sequencer.sv
// tb/tb_piso_sequencer.sv - directed self-checking bench for piso_sequencer (DIV=3 and DIV=1)
module tb_piso_sequencer;

  logic       CLK = 1'b0;
  logic       rst0, valid0, ready0, load0, ce0, busy0, done0;
  logic [3:0] i0, pi0;
  logic       rst1, valid1, ready1, load1, ce1, busy1, done1;
  logic [3:0] i1, pi1;
  logic [3:0] q0 = 4'd0, q1 = 4'd0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  piso_sequencer #(.WIDTH(4), .DIV(3)) u0 (
    .CLK(CLK), .RESET(rst0), .I(i0), .VALID(valid0), .READY(ready0),
    .PI(pi0), .LOAD(load0), .CE(ce0), .BUSY(busy0), .DONE(done0)
  );

  piso_sequencer #(.WIDTH(4), .DIV(1)) u1 (
    .CLK(CLK), .RESET(rst1), .I(i1), .VALID(valid1), .READY(ready1),
    .PI(pi1), .LOAD(load1), .CE(ce1), .BUSY(busy1), .DONE(done1)
  );

  // PISO4CE models fed by each sequencer; serial output is the MSB.
  always @(posedge CLK) begin
    if (ce0) q0 <= load0 ? pi0 : {q0[2:0], 1'b0};
    if (ce1) q1 <= load1 ? pi1 : {q1[2:0], 1'b0};
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] w1, w2, w3;
    logic       exp_bit;
    w1 = 4'b1011;
    w2 = 4'b0110;
    w3 = 4'b1001;

    // Reset with VALID asserted: nothing may be accepted.
    rst0 = 1; valid0 = 1; i0 = 4'hF;
    rst1 = 1; valid1 = 1; i1 = 4'hF;
    step();
    chk("rst_busy", 0, busy0, 0);
    chk("rst_pi", 0, pi0, 0);
    step();
    chk("rst_busy2", 1, busy0, 0);
    chk("rst_pi2", 1, pi0, 0);
    rst0 = 0; valid0 = 0; rst1 = 0; valid1 = 0; i1 = 4'h0;
    #1;
    chk("rst_ready", 2, ready0, 1);
    chk("rst_load", 2, load0, 0);
    chk("rst_ce", 2, ce0, 0);
    chk("rst_done", 2, done0, 0);
    chk("rst_ready1", 2, ready1, 1);
    chk("rst_busy1", 2, busy1, 0);

    // Single word, busy rejection, back-to-back second word (DIV=3).
    for (int c = 0; c <= 32; c++) begin
      if (c == 0)                 begin valid0 = 1; i0 = w1;    end
      else if (c == 1)            begin valid0 = 0;             end
      else if (c >= 2 && c <= 15) begin valid0 = 1; i0 = 4'h5;  end
      else if (c == 16)           begin valid0 = 1; i0 = w2;    end
      else                        begin valid0 = 0; i0 = 4'hA;  end
      #1;
      chk("ready", c, ready0, (c == 0 || c == 16 || c == 32));
      chk("load", c, load0, ((c >= 1 && c <= 3) || (c >= 17 && c <= 19)));
      chk("ce", c, ce0, (c == 3 || c == 6 || c == 9 || c == 12 ||
                         c == 19 || c == 22 || c == 25 || c == 28));
      chk("done", c, done0, (c == 16 || c == 32));
      chk("busy", c, busy0, ((c >= 1 && c <= 15) || (c >= 17 && c <= 31)));
      chk("pi", c, pi0, (c == 0) ? 4'h0 : (c <= 16) ? w1 : w2);
      if (c >= 4 && c <= 15) begin
        exp_bit = w1[3 - (c - 4) / 3];
        chk("serial1", c, q0[3], exp_bit);
      end
      if (c >= 20 && c <= 31) begin
        exp_bit = w2[3 - (c - 20) / 3];
        chk("serial2", c, q0[3], exp_bit);
      end
      step();
    end
    valid0 = 0;

    // Reset mid-shift: abort without a DONE pulse.
    for (int c = 0; c <= 17; c++) begin
      valid0 = (c == 0);
      i0     = w1;
      rst0   = (c == 8);
      #1;
      if (c >= 1 && c <= 8) chk("abort_busy", c, busy0, 1);
      if (c == 3 || c == 6) chk("abort_ce_pre", c, ce0, 1);
      if (c >= 9) begin
        chk("abort_ready", c, ready0, 1);
        chk("abort_idle", c, busy0, 0);
        chk("abort_ce", c, ce0, 0);
        chk("abort_load", c, load0, 0);
        chk("abort_done", c, done0, 0);
        chk("abort_pi", c, pi0, 0);
      end
      step();
    end
    rst0 = 0; valid0 = 0;

    // DIV=1: one LOADING cycle then a contiguous CE burst.
    for (int c = 0; c <= 8; c++) begin
      valid1 = (c == 0);
      i1     = w3;
      #1;
      chk("d1_load", c, load1, (c == 1));
      chk("d1_ce", c, ce1, (c >= 1 && c <= 4));
      chk("d1_done", c, done1, (c == 6));
      chk("d1_ready", c, ready1, (c == 0 || c >= 6));
      chk("d1_busy", c, busy1, (c >= 1 && c <= 5));
      if (c >= 2 && c <= 5) begin
        exp_bit = w3[3 - (c - 2)];
        chk("d1_serial", c, q1[3], exp_bit);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_sequencer.md
Name: piso_sequencer

Overview:
Controller that sequences a PISO shift register with clock enable (PISO<WIDTH>CE) to serialise parallel words, MSB first.
- Owns the bit-period divider, replacing the free-running Counter COUT used as shift enable.
- Accepts words over a VALID/READY handshake and drives the PISO LOAD and CE.
- Signals completion.
- Sits between a word producer and the PISO on the icestick top level.

Parameters:
- WIDTH, 4, PISO width / bits per word (>=2)
- DIV, 3, clock cycles per bit period (>=1); divider counter width is clog2(DIV), minimum 1

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- I  input  WIDTH  word to send
- VALID  input  1  producer has a word on I
- READY  output  1  sequencer can accept a word
- PI  output  WIDTH  captured word, wired to PISO PI
- LOAD  output  1  to PISO LOAD
- CE  output  1  to PISO CE
- BUSY  output  1  word in flight
- DONE  output  1  one-cycle pulse, last bit period finished

Behaviour:
- States: IDLE, LOADING, SHIFTING. Registers: state, divcnt, bitcnt (clog2(WIDTH)+1 bits), PI.
- Reset values (cycle after RESET is sampled high): state=IDLE, divcnt=0, bitcnt=0, PI=0, DONE=0. Resulting outputs: READY=1, LOAD=0, CE=0, BUSY=0.
- tick = (divcnt==DIV-1) while state!=IDLE.
  - divcnt increments when not tick and wraps to 0 on tick.
  - divcnt is held at 0 in IDLE.
- IDLE:
  - READY=1, BUSY=0, LOAD=0, CE=0.
  - On VALID&READY: PI<=I, divcnt<=0, go to LOADING.
  - VALID without a transition leaves PI unchanged.
- LOADING:
  - LOAD=1, CE=tick, BUSY=1, READY=0.
  - On tick the PISO loads PI; bitcnt<=0; go to SHIFTING.
- SHIFTING:
  - LOAD=0, BUSY=1, READY=0.
  - CE = tick & (bitcnt<WIDTH-1).
  - On tick: bitcnt++.
  - On tick with bitcnt==WIDTH-1: no CE, go to IDLE, DONE<=1. The last bit keeps its full period and SI is never shifted in by the sequencer.
- DONE is registered and high exactly in the first IDLE cycle after SHIFTING. READY is also high in that cycle, so an accept can coincide with DONE (back-to-back).
- Timing, accept at cycle 0:
  - LOADING occupies cycles 1..DIV.
  - PISO bit k (MSB first, k=0..WIDTH-1) is on the PISO output for cycles DIV*(k+1)+1 .. DIV*(k+2).
  - DONE is at cycle DIV*(WIDTH+1)+1.
- VALID while BUSY is ignored. I is sampled only on the accept edge; later changes to I do not affect PI.
- RESET mid-operation (any state): return to IDLE next cycle; PI cleared; CE/LOAD low from that cycle; no DONE pulse. RESET has priority over a simultaneous accept.
- DIV=1: tick every non-IDLE cycle; CE is a contiguous WIDTH-1 cycle burst after the single LOADING cycle.
- All outputs are functions of registered state plus divcnt only; there is no combinational path from VALID/I to outputs, except READY, which depends on state only.

Decomposition:
- Shared package: state encoding constants (IDLE=0, LOADING=1, SHIFTING=2) and a clog2 helper.
- Natural sub-module: piso_bit_timer, a DIV divider with clear, enable and tick output. It replaces Counter22's role as shift-enable source; the FSM, bit counter and PI capture stay in piso_sequencer.
- The PISO itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset: RESET high 2 cycles with VALID=1, I=4'hF → after release, READY=1, BUSY=0, LOAD=CE=DONE=0, PI=0; no accept while RESET high.
- Single word, WIDTH=4, DIV=3, I=4'b1011 accepted at cycle 0 →
  - LOAD=1 cycles 1..3; CE=1 at cycles 3,6,9,12 only.
  - PISO model output 1,0,1,1 over cycles 4-6, 7-9, 10-12, 13-15.
  - DONE=1 at cycle 16 only.
- Busy rejection: VALID=1, I=4'h5 during cycles 2..15 of the above → READY=0 throughout, PI stays 4'b1011, serial output unchanged.
- Back-to-back: VALID held with I=4'b0110 at cycle 16 → accepted alongside DONE; LOAD=1 cycles 17..19; second word serialised as 0,1,1,0 over cycles 20-31.
- Reset mid-shift: RESET at cycle 8 of the single-word case → cycle 9 onwards state IDLE, CE=LOAD=0, no DONE, READY=1.
- DIV=1, WIDTH=4, I=4'b1001 at cycle 0 → LOAD cycle 1; CE cycles 1,2,3,4; serial 1,0,0,1 cycles 2-5; DONE cycle 6.
